// File: rtl/qam_pkg.sv
// Shared definitions for the QAM bit scheduler: FSM state encoding,
// counter widths and default timing parameters.
package qam_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SMP  = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  localparam int BPS_MAX       = 8;
  localparam int DEF_BPS       = 4;
  localparam int DEF_BIT_DIV   = 8;
  localparam int DEF_SMP_DLY   = 2;
  localparam int DEF_FRAME_LEN = 64;

  localparam int BCNT_W = $clog2(BPS_MAX);
  localparam int FCNT_W = 16;

endpackage

// File: rtl/qam_sym_outreg.sv
// Single-entry holding register for {sym_last, sym_data}. A load and a
// drain may happen in the same cycle, so a steady stream has no bubbles.
module qam_sym_outreg #(
  parameter int W = 5
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drain
);

  logic         r_full;
  logic [W-1:0] r_data;

  // Handshake: a word transfers on every cycle where valid && ready; while
  // valid is high and ready is low, the word is held unchanged.
  assign o_drain = r_full & i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (o_drain) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/qam_bit_sched.sv
// Paces bit requests to the serial generator, packs returned bits MSB-first
// into symbols and hands them to the mapper; stalls requests on backpressure.
module qam_bit_sched
  import qam_pkg::*;
#(
  parameter int BPS       = DEF_BPS,
  parameter int BIT_DIV   = DEF_BIT_DIV,
  parameter int SMP_DLY   = DEF_SMP_DLY,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic           i_run,
  input  logic           i_bit_in,
  output logic           o_bit_req,
  output logic [BPS-1:0] o_sym_data,
  output logic           o_sym_valid,
  input  logic           i_sym_ready,
  output logic           o_sym_last,
  output logic           o_busy,
  output logic [2:0]     o_state
);

  // r_pace holds (cycles since the last bit_req) - 1, so the next request is
  // issued after PACE_END and the sample is taken SMP_DLY cycles after REQ.
  localparam int PACE_W = $clog2(BIT_DIV);
  localparam logic [PACE_W-1:0] PACE_SMP  = PACE_W'(SMP_DLY - 1);
  localparam logic [PACE_W-1:0] PACE_END  = PACE_W'(BIT_DIV - 2);
  localparam logic [PACE_W-1:0] PACE_MAX  = PACE_W'(BIT_DIV - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BPS - 1);
  localparam logic [FCNT_W-1:0] FRM_LAST  = FCNT_W'(FRAME_LEN - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [PACE_W-1:0] r_pace;
  logic [BCNT_W-1:0] r_bitcnt;
  logic [BCNT_W-1:0] w_bitcnt_nxt;
  logic [FCNT_W-1:0] r_symcnt;
  logic [BPS-1:0]    r_acc;
  logic [BPS-1:0]    w_acc_nxt;
  logic              w_full;
  logic              w_drain;
  logic              w_can_load;
  logic              w_last_bit;
  logic              w_load;
  logic              w_pace_end;
  logic [BPS:0]      w_load_word;
  logic [BPS:0]      w_out_word;

  assign w_acc_nxt   = (r_acc << 1) | BPS'(i_bit_in);
  assign w_pace_end  = (r_pace == PACE_END);
  assign w_last_bit  = (r_state == ST_SMP) && (r_bitcnt == BCNT_LAST);
  assign w_can_load  = !w_full || w_drain;
  assign w_load      = (w_last_bit && w_can_load) || ((r_state == ST_HOLD) && w_drain);
  assign w_load_word = {(r_symcnt == FRM_LAST), (r_state == ST_HOLD) ? r_acc : w_acc_nxt};

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    case (r_state)
      ST_IDLE: begin
        w_bitcnt_nxt = '0;
        if (i_run) w_state_nxt = ST_REQ;
      end
      ST_REQ: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (r_pace == PACE_SMP) begin
          w_state_nxt = ST_SMP;
        end else if (w_pace_end) begin
          w_state_nxt = (i_run || (r_bitcnt != '0)) ? ST_REQ : ST_IDLE;
        end
      end
      ST_SMP: begin
        if (!w_last_bit) begin
          w_bitcnt_nxt = r_bitcnt + 1'b1;
        end else if (w_can_load) begin
          w_bitcnt_nxt = '0;
        end
        // A finished symbol that cannot be handed over parks in r_acc.
        if (w_last_bit && !w_can_load) begin
          w_state_nxt = ST_HOLD;
        end else if (w_pace_end) begin
          w_state_nxt = (i_run || (w_bitcnt_nxt != '0)) ? ST_REQ : ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (w_drain) begin
          w_bitcnt_nxt = '0;
          w_state_nxt  = i_run ? ST_REQ : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_bitcnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_pace   <= '0;
      r_bitcnt <= '0;
      r_symcnt <= '0;
      r_acc    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      if (r_state == ST_REQ) begin
        r_pace <= '0;
      end else if (r_pace != PACE_MAX) begin
        r_pace <= r_pace + 1'b1;
      end
      if (r_state == ST_SMP) r_acc <= w_acc_nxt;
      if (r_state == ST_IDLE) begin
        r_symcnt <= '0;
      end else if (w_load) begin
        r_symcnt <= (r_symcnt == FRM_LAST) ? '0 : r_symcnt + 1'b1;
      end
    end
  end

  qam_sym_outreg #(
    .W (BPS + 1)
  ) u_outreg (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .i_data    (w_load_word),
    .i_ready   (i_sym_ready),
    .o_valid   (w_full),
    .o_data    (w_out_word),
    .o_drain   (w_drain)
  );

  assign o_bit_req   = (r_state == ST_REQ);
  assign o_sym_valid = w_full;
  assign o_sym_data  = w_out_word[BPS-1:0];
  assign o_sym_last  = w_out_word[BPS];
  assign o_busy      = (r_state != ST_IDLE);
  assign o_state     = r_state;

endmodule

// File: tb/tb_qam_bit_sched.sv
// Directed and randomized bench for qam_bit_sched: a generator responder,
// a bit-stream symbol model with an expected queue, and directed steps.
module tb_qam_bit_sched;
  import qam_pkg::*;

  localparam int BPS       = 4;
  localparam int BIT_DIV   = 8;
  localparam int SMP_DLY   = 2;
  localparam int FRAME_LEN = 3;

  logic           clk;
  logic           rst_n;
  logic           run;
  logic           bit_in;
  logic           bit_req;
  logic [BPS-1:0] sym_data;
  logic           sym_valid;
  logic           sym_ready;
  logic           sym_last;
  logic           busy;
  logic [2:0]     state;

  qam_bit_sched #(
    .BPS       (BPS),
    .BIT_DIV   (BIT_DIV),
    .SMP_DLY   (SMP_DLY),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_run       (run),
    .i_bit_in    (bit_in),
    .o_bit_req   (bit_req),
    .o_sym_data  (sym_data),
    .o_sym_valid (sym_valid),
    .i_sym_ready (sym_ready),
    .o_sym_last  (sym_last),
    .o_busy      (busy),
    .o_state     (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters and model state ----------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [BPS:0]   exp_q[$];
  logic [BPS-1:0] got_data_q[$];
  logic           got_last_q[$];
  logic [BPS-1:0] m_acc = '0;
  int             m_n = 0;
  int             m_frame = 0;
  int             n_acc = 0;
  bit             pat_mode = 1'b1;
  int             pat_idx = 0;
  logic [7:0]     pat = 8'b0110_1100;
  bit             chk_period = 1'b0;

  int t_r, t_v, t_n0;
  bit t_ok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- generator responder and scoreboard ----------------
  initial begin : monitor
    int cyc;
    int last_req_cyc;
    bit prev_req;
    bit prev_hold;
    logic [BPS:0] prev_word;
    logic [BPS:0] w;
    logic b;
    cyc = 0;
    last_req_cyc = -1;
    prev_req = 1'b0;
    prev_hold = 1'b0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_req = 1'b0;
        prev_hold = 1'b0;
        last_req_cyc = -1;
      end else begin
        if (prev_hold) begin
          chk("hold_valid", sym_valid, 1);
          chk("hold_word", {sym_last, sym_data}, prev_word);
        end
        if (bit_req) begin
          chk("bit_req_adjacent", prev_req, 0);
          if (chk_period && last_req_cyc >= 0)
            chk("bit_req_period", cyc - last_req_cyc, BIT_DIV);
          last_req_cyc = cyc;
          b = pat_mode ? pat[7 - (pat_idx % 8)] : 1'($urandom_range(0, 1));
          pat_idx++;
          bit_in = b;
          m_acc = {m_acc[BPS-2:0], b};
          m_n++;
          if (m_n == BPS) begin
            m_frame++;
            exp_q.push_back({(m_frame == FRAME_LEN), m_acc});
            if (m_frame == FRAME_LEN) m_frame = 0;
            m_n = 0;
          end
        end
        if (sym_valid && sym_ready) begin
          chk("exp_q_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("sym_data", sym_data, w[BPS-1:0]);
            chk("sym_last", sym_last, w[BPS]);
          end
          got_data_q.push_back(sym_data);
          got_last_q.push_back(sym_last);
          n_acc++;
        end
        prev_req  = bit_req;
        prev_hold = sym_valid && !sym_ready;
        prev_word = {sym_last, sym_data};
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed steps ----------------
  initial begin : stim
    rst_n = 1'b0;
    run = 1'b1;
    sym_ready = 1'b1;
    bit_in = 1'b0;

    // Reset with run=1: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_bit_req", bit_req, 0);
    chk("rst_sym_valid", sym_valid, 0);
    chk("rst_sym_data", sym_data, 0);
    chk("rst_sym_last", sym_last, 0);
    chk("rst_busy", busy, 0);

    chk_period = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_idle_cycle_req", bit_req, 0);
    chk("t1_idle_cycle_busy", busy, 0);
    @(negedge clk);
    chk("t1_first_req", bit_req, 1);
    chk("t1_busy", busy, 1);

    // Steady state with the fixed 0110_1100 pattern.
    repeat (64) @(negedge clk);
    t_v = 0;
    repeat (320) begin
      @(negedge clk);
      if (sym_valid) t_v++;
    end
    chk("t2_valid_cycles_per_320", t_v, 10);
    chk("t2_enough_symbols", got_data_q.size() >= 10, 1);
    if (got_data_q.size() >= 10) begin
      chk("t2_sym0", got_data_q[0], 4'h6);
      chk("t2_sym1", got_data_q[1], 4'hC);
      chk("t2_sym2", got_data_q[2], 4'h6);
      for (int k = 0; k < 9; k++)
        chk($sformatf("t4_last_sym%0d", k + 1), got_last_q[k], (k % 3) == 2);
    end
    chk_period = 1'b0;
    pat_mode = 1'b0;

    // Backpressure: stall for 100 cycles.
    @(posedge clk); #1 sym_ready = 1'b0;
    t_r = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i >= 70 && bit_req) t_r++;
    end
    chk("t3_no_req_when_stalled", t_r, 0);
    chk("t3_state_hold", state, ST_HOLD);
    chk("t3_pending_symbols", exp_q.size(), 2);
    chk("t3_no_partial_bits", m_n, 0);
    chk("t3_valid_held", sym_valid, 1);

    // Random backpressure.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1 sym_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 sym_ready = 1'b1;

    // run drop after two bits of a symbol.
    t_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_n == 2) begin
        t_ok = 1'b1;
        break;
      end
    end
    chk("t5_two_bits_seen", t_ok, 1);
    t_n0 = n_acc;
    @(posedge clk); #1 run = 1'b0;
    t_r = 0;
    t_ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bit_req) t_r++;
      if (!busy) begin
        t_ok = 1'b1;
        break;
      end
    end
    chk("t5_busy_drops", t_ok, 1);
    chk("t5_extra_reqs", t_r, 2);
    chk("t5_no_partial_bits", m_n, 0);
    repeat (5) @(negedge clk);
    chk("t5_one_symbol_out", n_acc - t_n0, 1);
    chk("t5_queue_empty", exp_q.size(), 0);
    t_r = 0;
    repeat (20) begin
      @(negedge clk);
      if (bit_req || busy) t_r++;
    end
    chk("t5_idle_quiet", t_r, 0);

    m_frame = 0;
    got_last_q.delete();
    @(posedge clk); #1 run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (got_last_q.size() >= 4) break;
    end
    chk("t5_restart_symbols", got_last_q.size() >= 4, 1);
    if (got_last_q.size() >= 4) begin
      chk("t5_restart_last0", got_last_q[0], 0);
      chk("t5_restart_last1", got_last_q[1], 0);
      chk("t5_restart_last2", got_last_q[2], 1);
      chk("t5_restart_last3", got_last_q[3], 0);
    end

    // Async reset in WAIT with a held symbol and a partial one.
    @(posedge clk); #1 sym_ready = 1'b0;
    t_ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sym_valid && state == ST_WAIT && m_n >= 1) begin
        t_ok = 1'b1;
        break;
      end
    end
    chk("t6_wait_with_valid", t_ok, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_bit_req", bit_req, 0);
    chk("t6_async_sym_valid", sym_valid, 0);
    chk("t6_async_sym_data", sym_data, 0);
    chk("t6_async_sym_last", sym_last, 0);
    chk("t6_async_busy", busy, 0);
    exp_q.delete();
    m_n = 0;
    m_acc = '0;
    m_frame = 0;
    repeat (2) @(posedge clk);
    #1 sym_ready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_cycle_req", bit_req, 0);
    @(negedge clk);
    chk("t6_first_req", bit_req, 1);
    t_n0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_acc - t_n0 >= 8) break;
    end
    chk("t6_resumed_symbols", n_acc - t_n0 >= 8, 1);

    // Drain and finish.
    @(posedge clk); #1 run = 1'b0;
    t_ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !sym_valid && exp_q.size() == 0) begin
        t_ok = 1'b1;
        break;
      end
    end
    chk("end_drained", t_ok, 1);
    chk("end_no_partial_bits", m_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
